// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg -- shared definitions for the instruction-fetch path.
//   ps_e            : PC-select encodings driven on the PS control input.
//   fetch_state_e   : fetch FSM state type (IDLE waits, REQ holds a bus request).
//   OPCODE_MSB/LSB  : position of the opcode field inside an instruction word.
//   IMM_MSB/LSB     : position of the 8-bit branch displacement.
// ---------------------------------------------------------------------------
package cpu_pkg;

  typedef enum logic [1:0] {
    PS_HOLD = 2'b00,
    PS_INC  = 2'b01,
    PS_BR   = 2'b10,
    PS_JR   = 2'b11
  } ps_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } fetch_state_e;

  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 12;
  localparam int OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;

  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;
  localparam int IMM_W   = IMM_MSB - IMM_LSB + 1;

endpackage

// File: rtl/fetch_pc_next.sv
// ---------------------------------------------------------------------------
// fetch_pc_next -- combinational next-PC selection.
//   pc_i       : current program counter
//   ps_i       : PC select (hold / increment / branch / jump-register)
//   imm_i      : signed 8-bit branch displacement, relative to pc+1
//   jr_addr_i  : jump-register target
//   pc_next_o  : selected next PC (all arithmetic wraps modulo 2^PC_W)
//   pc_inc_o   : pc+1, also used as the link (return) address
// ---------------------------------------------------------------------------
module fetch_pc_next
  import cpu_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic [PC_W-1:0]  pc_i,
  input  logic [1:0]       ps_i,
  input  logic [IMM_W-1:0] imm_i,
  input  logic [PC_W-1:0]  jr_addr_i,
  output logic [PC_W-1:0]  pc_next_o,
  output logic [PC_W-1:0]  pc_inc_o
);

  logic [PC_W-1:0] offset;

  // Sign-extend (or truncate) the displacement to PC width; modulo-2^PC_W
  // addition then gives the same result as a full-width signed add.
  assign offset   = PC_W'($signed(imm_i));
  assign pc_inc_o = pc_i + PC_W'(1);

  always_comb begin
    // NOTE: default assignment first so every path drives the output and no latch is inferred.
    pc_next_o = pc_i;
    case (ps_e'(ps_i))
      PS_HOLD: pc_next_o = pc_i;
      PS_INC:  pc_next_o = pc_inc_o;
      PS_BR:   pc_next_o = pc_inc_o + offset;
      PS_JR:   pc_next_o = jr_addr_i;
      default: pc_next_o = pc_i;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit -- program counter, link register and instruction fetch FSM.
//   clk, rst          : rising-edge clock, asynchronous active-high reset
//   IL                : start a fetch of the word at pc (accepted in IDLE only)
//   PS, pc_en, WP     : PC update select, apply strobe, capture link address
//   jr_addr           : jump-register target
//   imem_req/addr     : memory request, held with a stable address until ack
//   imem_ack/rdata    : memory response
//   instr, opcode     : instruction register and its opcode field
//   pc, link_addr     : current PC and registered return address
//   busy, fetch_done  : fetch in progress / one-cycle pulse after instr loads
//   timeout_err       : sticky bus-timeout flag (only with FETCH_TIMEOUT_EN)
// Build option: define FETCH_TIMEOUT_EN to abandon a fetch after 15 cycles
// without ack and flag it on timeout_err.
// ---------------------------------------------------------------------------
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int          PC_W     = 8,
  parameter int          INSTR_W  = 16,
  parameter int unsigned RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               IL,
  input  logic [1:0]         PS,
  input  logic               pc_en,
  input  logic               WP,
  input  logic [PC_W-1:0]    jr_addr,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [3:0]         opcode,
  output logic [PC_W-1:0]    pc,
  output logic [PC_W-1:0]    link_addr,
  output logic               busy,
  output logic               fetch_done
`ifdef FETCH_TIMEOUT_EN
  ,
  output logic               timeout_err
`endif
);

  fetch_state_e       state_q;
  logic               req_q;
  logic               done_q;
  logic [PC_W-1:0]    pc_q;
  logic [PC_W-1:0]    link_q;
  logic [INSTR_W-1:0] instr_q;
  logic [PC_W-1:0]    pc_d;
  logic [PC_W-1:0]    pc_inc;

`ifdef FETCH_TIMEOUT_EN
  // The counter reads 14 during the 15th cycle spent in REQ.
  localparam logic [3:0] TMO_LAST = 4'd14;
  logic [3:0] tmo_cnt_q;
  logic       timeout_err_q;
`endif

  fetch_pc_next #(
    .PC_W (PC_W)
  ) u_pc_next (
    .pc_i      (pc_q),
    .ps_i      (PS),
    .imm_i     (instr_q[IMM_MSB:IMM_LSB]),
    .jr_addr_i (jr_addr),
    .pc_next_o (pc_d),
    .pc_inc_o  (pc_inc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: instr and link are architecturally visible, so they are reset
      // too; async reset also drops imem_req mid-fetch without waiting for a clock.
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      pc_q    <= PC_W'(RESET_PC);
      link_q  <= '0;
      instr_q <= '0;
`ifdef FETCH_TIMEOUT_EN
      tmo_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // The PC update lands on the same edge that enters REQ, so a
          // combined IL + pc_en fetch uses the updated PC.
          if (pc_en) begin
            pc_q <= pc_d;
            if (WP) link_q <= pc_inc;
          end
          if (IL) begin
            state_q <= S_REQ;
            req_q   <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
            tmo_cnt_q <= '0;
`endif
          end
        end
        S_REQ: begin
          // pc_en and IL are ignored here; pc (and so imem_addr) stays put.
          if (imem_ack) begin
            instr_q <= imem_rdata;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
            req_q   <= 1'b0;
          end
`ifdef FETCH_TIMEOUT_EN
          else if (tmo_cnt_q == TMO_LAST) begin
            state_q       <= S_IDLE;
            req_q         <= 1'b0;
            timeout_err_q <= 1'b1;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 4'd1;
          end
`endif
        end
        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req   = req_q;
  assign busy       = req_q;
  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign link_addr  = link_q;
  assign instr      = instr_q;
  assign opcode     = instr_q[OPCODE_MSB:OPCODE_LSB];
  assign fetch_done = done_q;
`ifdef FETCH_TIMEOUT_EN
  assign timeout_err = timeout_err_q;
`endif

endmodule
